// File: rtl/px_lane_deskew.sv
// Multi-lane line deskew: per-lane FIFOs absorb lane skew, then all enabled
// lanes are popped in lock-step for one line of ACTIVE_WIDTH words.
module px_lane_fifo #(
  parameter int PW    = 12,
  parameter int DEPTH = 16
) (
  input  logic          px_clk,
  input  logic          px_reset_n,
  input  logic          clr,
  input  logic          wr,
  input  logic          rd,
  input  logic [PW-1:0] din,
  output logic [PW-1:0] dout,
  output logic          empty,
  output logic          wr_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, do_rd, do_wr;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_rd   = rd & ~empty;
  // A pop in the same cycle frees the slot, so write+pop on a full FIFO is fine.
  assign do_wr   = wr & (~full | do_rd);
  assign wr_drop = wr & ~do_wr;
  assign dout    = mem[rp];

  always_ff @(posedge px_clk)
    if (do_wr) mem[wp] <= din;

  always_ff @(posedge px_clk or negedge px_reset_n)
    if (!px_reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
endmodule

module px_lane_deskew #(
  parameter int D     = 4,
  parameter int PW    = 12,
  parameter int DEPTH = 16
) (
  input  logic          px_clk,
  input  logic          px_reset_n,
  input  logic [15:0]   ACTIVE_WIDTH,
  input  logic [D-1:0]  lane_mask,
  input  logic          stream_on_in,
  input  logic          err_clr,
  input  logic [D*PW-1:0] px_data_in,
  input  logic [D-1:0]  px_en_in,
  input  logic [D-1:0]  px_vs_in,
  output logic [D*PW-1:0] sen_dout,
  output logic          sen_en_out,
  output logic          sen_vs_out,
  output logic [15:0]   line_cnt_out,
  output logic          ovf_err_out,
  output logic          udf_err_out
);
  typedef enum logic [2:0] {IDLE, ARMED, WAIT_LINE, OUTPUT, FLUSH} state_t;

  state_t state, state_nxt;
  logic   vs_all, vs_any, vs_all_q, all_ready, pop, fifo_clr;
  logic   start_frame, line_start, line_end, to_flush;
  logic [15:0] words_left;
  logic [D-1:0] wr, empty, wr_drop;
  logic [D-1:0][PW-1:0] head, dout_nxt;

  assign vs_all    = &(px_vs_in | ~lane_mask);
  assign vs_any    = |(px_vs_in & lane_mask);
  assign all_ready = ~|(empty & lane_mask);
  assign pop       = (state == OUTPUT);
  assign fifo_clr  = start_frame | (state == FLUSH);

  for (genvar i = 0; i < D; i++) begin : g_lane
    assign wr[i] = px_en_in[i] & lane_mask[i] & ((state == WAIT_LINE) | (state == OUTPUT));
    // Masked lanes are held in clear so they never report data or errors.
    px_lane_fifo #(.PW(PW), .DEPTH(DEPTH)) u_fifo (
      .px_clk     (px_clk),
      .px_reset_n (px_reset_n),
      .clr        (fifo_clr | ~lane_mask[i]),
      .wr         (wr[i]),
      .rd         (pop & lane_mask[i]),
      .din        (px_data_in[PW*i +: PW]),
      .dout       (head[i]),
      .empty      (empty[i]),
      .wr_drop    (wr_drop[i])
    );
    assign dout_nxt[i] = (pop & lane_mask[i] & ~empty[i]) ? head[i] : '0;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    line_start  = 1'b0;
    line_end    = 1'b0;
    to_flush    = 1'b0;
    unique case (state)
      IDLE:      if (stream_on_in && lane_mask != '0) state_nxt = ARMED;
      ARMED:
        if (!stream_on_in) state_nxt = IDLE;
        else if (vs_all && !vs_all_q) begin
          state_nxt   = WAIT_LINE;
          start_frame = 1'b1;
        end
      WAIT_LINE:
        if (!vs_any) begin
          state_nxt = FLUSH;
          to_flush  = 1'b1;
        end else if (all_ready) begin
          state_nxt  = OUTPUT;
          line_start = 1'b1;
        end
      OUTPUT:
        if (words_left == 16'd1) begin
          state_nxt = WAIT_LINE;
          line_end  = 1'b1;
        end
      FLUSH:     state_nxt = stream_on_in ? ARMED : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge px_clk or negedge px_reset_n)
    if (!px_reset_n) begin
      state        <= IDLE;
      vs_all_q     <= 1'b0;
      words_left   <= '0;
      sen_dout     <= '0;
      sen_en_out   <= 1'b0;
      sen_vs_out   <= 1'b0;
      line_cnt_out <= '0;
      ovf_err_out  <= 1'b0;
      udf_err_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_all_q   <= vs_all;
      sen_dout   <= dout_nxt;
      sen_en_out <= pop;
      if (line_start)  words_left <= (ACTIVE_WIDTH == '0) ? 16'd1 : ACTIVE_WIDTH;
      else if (pop)    words_left <= words_left - 16'd1;
      if (start_frame) sen_vs_out <= 1'b1;
      else if (to_flush) sen_vs_out <= 1'b0;
      if (start_frame) line_cnt_out <= '0;
      else if (line_end && line_cnt_out != 16'hFFFF) line_cnt_out <= line_cnt_out + 16'd1;
      // New error events win over a same-cycle clear.
      ovf_err_out <= (|wr_drop) | (ovf_err_out & ~err_clr);
      udf_err_out <= (pop & |(empty & lane_mask)) | (udf_err_out & ~err_clr);
    end
endmodule

// File: tb/tb_px_lane_deskew.sv
// Bench for px_lane_deskew: queue-based reference model compared every cycle,
// plus directed frames with hand-computed expectations.
module tb_px_lane_deskew;
  localparam int D = 4, PW = 12, DEP = 16;

  logic px_clk = 1'b0, px_reset_n = 1'b1;
  logic [15:0] active_width = 16'd8;
  logic [D-1:0] lane_mask = '1;
  logic stream_on = 1'b0, err_clr = 1'b0;
  logic [D*PW-1:0] px_data = '0;
  logic [D-1:0] px_en = '0, px_vs = '0;
  logic [D*PW-1:0] sen_dout;
  logic sen_en, sen_vs, ovf, udf;
  logic [15:0] line_cnt;

  px_lane_deskew #(.D(D), .PW(PW), .DEPTH(DEP)) dut (
    .px_clk(px_clk), .px_reset_n(px_reset_n), .ACTIVE_WIDTH(active_width),
    .lane_mask(lane_mask), .stream_on_in(stream_on), .err_clr(err_clr),
    .px_data_in(px_data), .px_en_in(px_en), .px_vs_in(px_vs),
    .sen_dout(sen_dout), .sen_en_out(sen_en), .sen_vs_out(sen_vs),
    .line_cnt_out(line_cnt), .ovf_err_out(ovf), .udf_err_out(udf));

  always #5 px_clk = ~px_clk;

  int cyc = 0;
  always @(posedge px_clk) cyc = cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: lanes as queues, a frame phase and a words-remaining count.
  localparam int P_OFF = 0, P_ARM = 1, P_GAP = 2, P_LINE = 3, P_END = 4;
  logic [PW-1:0] mq [D][$];
  int m_ph = P_OFF, m_left = 0;
  bit m_vsq = 0, m_en = 0, m_vs = 0, m_ovf = 0, m_udf = 0;
  logic [D*PW-1:0] m_dout = '0;
  logic [15:0] m_lines = '0;

  always @(posedge px_clk or negedge px_reset_n) begin : model
    bit vall, vany, ready, oset, uset, rise, fl;
    int ph;
    if (!px_reset_n) begin
      for (int i = 0; i < D; i++) mq[i].delete();
      m_ph = P_OFF; m_left = 0; m_vsq = 0; m_en = 0; m_vs = 0;
      m_ovf = 0; m_udf = 0; m_dout = '0; m_lines = '0;
    end else begin
      vall = 1; vany = 0; ready = 1; oset = 0; uset = 0; fl = 0;
      ph = m_ph;
      for (int i = 0; i < D; i++)
        if (lane_mask[i]) begin
          vall &= px_vs[i];
          vany |= px_vs[i];
          if (mq[i].size() == 0) ready = 0;
        end
      rise = vall && !m_vsq;
      m_vsq = vall;
      m_en = (ph == P_LINE);
      m_dout = '0;
      if (ph == P_LINE)
        for (int i = 0; i < D; i++)
          if (lane_mask[i]) begin
            if (mq[i].size() > 0) m_dout[PW*i +: PW] = mq[i].pop_front();
            else uset = 1;
          end
      if (ph == P_GAP || ph == P_LINE)
        for (int i = 0; i < D; i++)
          if (lane_mask[i] && px_en[i]) begin
            if (mq[i].size() < DEP) mq[i].push_back(px_data[PW*i +: PW]);
            else oset = 1;
          end
      case (ph)
        P_OFF: if (stream_on && lane_mask != '0) m_ph = P_ARM;
        P_ARM:
          if (!stream_on) m_ph = P_OFF;
          else if (rise) begin m_ph = P_GAP; m_vs = 1; m_lines = '0; fl = 1; end
        P_GAP:
          if (!vany) begin m_ph = P_END; m_vs = 0; end
          else if (ready) begin m_ph = P_LINE; m_left = (active_width == 0) ? 1 : int'(active_width); end
        P_LINE: begin
          m_left--;
          if (m_left == 0) begin
            m_ph = P_GAP;
            if (m_lines != 16'hFFFF) m_lines = m_lines + 16'd1;
          end
        end
        default: begin fl = 1; m_ph = stream_on ? P_ARM : P_OFF; end
      endcase
      for (int i = 0; i < D; i++) if (fl || !lane_mask[i]) mq[i].delete();
      m_ovf = oset | (m_ovf & !err_clr);
      m_udf = uset | (m_udf & !err_clr);
    end
  end

  logic [D*PW-1:0] cap [$];
  int t_en = -1, t_wr = -1;

  always @(negedge px_clk) begin
    n_cmp++;
    if ({sen_dout, sen_en, sen_vs, line_cnt, ovf, udf} !== {m_dout, m_en, m_vs, m_lines, m_ovf, m_udf}) begin
      n_bad++;
      $display("FAIL cyc%0d outputs: got dout=%h en=%b vs=%b lines=%0d ovf=%b udf=%b expected dout=%h en=%b vs=%b lines=%0d ovf=%b udf=%b",
               cyc, sen_dout, sen_en, sen_vs, line_cnt, ovf, udf, m_dout, m_en, m_vs, m_lines, m_ovf, m_udf);
    end
    if (sen_en === 1'b1) begin
      cap.push_back(sen_dout);
      if (t_en < 0) t_en = cyc;
    end
  end

  int f_nw[D], f_dsk[D];
  logic [D-1:0] g_mask = '0;

  function automatic logic [PW-1:0] word(input int i, input int j, input int k);
    return PW'((i << 10) | (j << 6) | k);
  endfunction

  task automatic run_frame(input int lines, input int period, input int drop_at, input int rst_at);
    int mx = 0, mw = 0, len;
    for (int i = 0; i < D; i++) begin
      if (f_dsk[i] > mx) mx = f_dsk[i];
      if (f_nw[i] > mw) mw = f_nw[i];
    end
    len = 4 + mx + (lines - 1) * period + mw + 4;
    cap.delete(); t_en = -1; t_wr = -1;
    for (int t = 0; t < len; t++) begin
      @(negedge px_clk);
      for (int i = 0; i < D; i++) begin
        int loc;
        loc = t - 4 - f_dsk[i];
        if (g_mask[i]) begin
          px_en[i] = 1'($urandom); px_vs[i] = 1'($urandom); px_data[PW*i +: PW] = PW'($urandom);
        end else begin
          px_vs[i] = 1'b1;
          if (loc >= 0 && loc / period < lines && loc % period < f_nw[i]) begin
            px_en[i] = 1'b1; px_data[PW*i +: PW] = word(i, loc / period, loc % period);
          end else begin
            px_en[i] = 1'b0; px_data[PW*i +: PW] = '0;
          end
        end
      end
      if (t == 4 + f_dsk[D-1]) t_wr = cyc + 1;
      if (t == drop_at) stream_on = 1'b0;
      if (t == rst_at) begin
        check("en_before_reset", 64'(sen_en), 64'd1);
        check("lines_before_reset", 64'(line_cnt), 64'd1);
        #2 px_reset_n = 1'b0;
        #1;
        check("rst_en", 64'(sen_en), 64'd0);
        check("rst_vs", 64'(sen_vs), 64'd0);
        check("rst_lines", 64'(line_cnt), 64'd0);
        px_en = '0; px_vs = '0; px_data = '0;
        repeat (2) @(negedge px_clk);
        #2 px_reset_n = 1'b1;
        break;
      end
    end
    @(negedge px_clk);
    px_en = '0; px_vs = '0; px_data = '0;
    repeat (6) @(negedge px_clk);
  endtask

  task automatic set_mask(input logic [D-1:0] m);
    @(negedge px_clk); stream_on = 1'b0;
    repeat (3) @(negedge px_clk);
    lane_mask = m; stream_on = 1'b1;
    repeat (3) @(negedge px_clk);
  endtask

  task automatic pulse_clr();
    @(negedge px_clk); err_clr = 1'b1;
    @(negedge px_clk); err_clr = 1'b0;
  endtask

  task automatic lanes_default();
    for (int i = 0; i < D; i++) begin f_nw[i] = 8; f_dsk[i] = 0; end
  endtask

  initial begin
    lanes_default();
    #1 px_reset_n = 1'b0;
    repeat (3) @(negedge px_clk);
    check("reset_dout", 64'(sen_dout), 64'd0);
    check("reset_en_vs", 64'({sen_en, sen_vs}), 64'd0);
    check("reset_lines", 64'(line_cnt), 64'd0);
    check("reset_err", 64'({ovf, udf}), 64'd0);
    #2 px_reset_n = 1'b1;
    @(negedge px_clk); stream_on = 1'b1;
    repeat (3) @(negedge px_clk);

    // skewed lanes 0/1/2/3
    for (int i = 0; i < D; i++) f_dsk[i] = i;
    run_frame(2, 12, -1, -1);
    check("skew_words", 64'(cap.size()), 64'd16);
    check("skew_first", 64'(cap.size() > 0 ? cap[0] : '0), 64'h c00800400000);
    check("skew_last", 64'(cap.size() > 15 ? cap[15] : '0), 64'h c47847447047);
    check("skew_latency", 64'(t_en - t_wr), 64'd2);
    check("skew_lines", 64'(line_cnt), 64'd2);
    check("skew_err", 64'({ovf, udf}), 64'd0);

    // lanes 1/3 masked and driven garbage
    lanes_default();
    set_mask(4'b0101); g_mask = 4'b1010;
    run_frame(2, 12, -1, -1);
    check("mask_words", 64'(cap.size()), 64'd16);
    check("mask_first", 64'(cap.size() > 0 ? cap[0] : '0), 64'h 000800000000);
    foreach (cap[k]) check("mask_zero_slices", 64'({cap[k][47:36], cap[k][23:12]}), 64'd0);
    check("mask_err", 64'({ovf, udf}), 64'd0);
    check("mask_lines", 64'(line_cnt), 64'd2);
    g_mask = '0; set_mask(4'b1111);

    // lane 2 late by 20 cycles overflows the other lanes
    f_dsk[2] = 20;
    run_frame(3, 8, -1, -1);
    check("ovf_set", 64'(ovf), 64'd1);
    pulse_clr();
    check("ovf_clr", 64'({ovf, udf}), 64'd0);

    // lane 1 one word short
    lanes_default(); f_nw[1] = 7;
    run_frame(1, 12, -1, -1);
    check("udf_set", 64'(udf), 64'd1);
    check("udf_lines", 64'(line_cnt), 64'd1);
    check("udf_words", 64'(cap.size()), 64'd8);
    check("udf_lane1_w8", 64'(cap.size() > 7 ? cap[7][23:0] : '0), 64'h 000007);
    check("udf_lane1_w7", 64'(cap.size() > 6 ? cap[6][23:12] : '0), 64'h 406);
    pulse_clr();
    check("udf_clr", 64'(udf), 64'd0);

    // stream_on drops after line 2 of 4
    lanes_default();
    run_frame(4, 12, 28, -1);
    check("drop_lines", 64'(line_cnt), 64'd4);
    check("drop_words", 64'(cap.size()), 64'd32);
    check("drop_vs", 64'(sen_vs), 64'd0);
    run_frame(1, 12, -1, -1);
    check("drop_ignored", 64'(cap.size()), 64'd0);
    check("drop_ignored_vs", 64'(sen_vs), 64'd0);

    // reset during the second line, then a clean frame
    @(negedge px_clk); stream_on = 1'b1;
    repeat (3) @(negedge px_clk);
    run_frame(3, 12, -1, 22);
    repeat (3) @(negedge px_clk);
    run_frame(2, 12, -1, -1);
    check("post_rst_words", 64'(cap.size()), 64'd16);
    check("post_rst_first", 64'(cap.size() > 0 ? cap[0] : '0), 64'h c00800400000);
    check("post_rst_lines", 64'(line_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
